// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings, FSM states,
// latency counter width and the captured request record.
package dmem_pkg;

  localparam int CNT_W = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  funct3;
    logic [31:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store mask/data placement and load extraction
// with sign/zero extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wmask,
  output logic [31:0] wword,
  output logic [31:0] ldata
);

  logic       is_b, is_h;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign is_b  = (funct3 == F3_B) || (funct3 == F3_BU);
  assign is_h  = (funct3 == F3_H) || (funct3 == F3_HU);
  assign rbyte = rword[8*addr_lo +: 8];
  assign rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];

  // Sub-word stores replicate the low data so every candidate lane carries it;
  // the mask alone decides which lanes commit.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign wmask[i] = is_b ? (addr_lo == 2'(i)) :
                      is_h ? (addr_lo[1] == 1'(i / 2)) : 1'b1;
    assign wword[8*i +: 8] = is_b ? wdata[7:0] :
                             is_h ? wdata[8*(i%2) +: 8] : wdata[8*i +: 8];
  end

  always_comb begin
    ldata = rword;
    case (funct3)
      F3_B:    ldata = {{24{rbyte[7]}}, rbyte};
      F3_BU:   ldata = {24'b0, rbyte};
      F3_H:    ldata = {{16{rhalf[15]}}, rhalf};
      F3_HU:   ldata = {16'b0, rhalf};
      default: ldata = rword;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with programmable latency over a
// word-organised store. DMEM_ERR_CHECK_EN enables alignment/range/funct3 checking.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  dmem_req_t        cap_q, acc;
  logic             acc_err, do_access;
  logic [IDX_W-1:0] widx;
  logic [31:0]      rword, wword, ldata, rsp_data_nxt;
  logic [3:0]       wmask;
  logic [31:0]      mem [DEPTH_WORDS];

  // With zero latency the access happens on the accept edge, before capture.
  assign acc  = (state == IDLE) ? dmem_req_t'{req_write, req_addr, req_funct3, req_wdata} : cap_q;
  assign widx = acc.addr[2 +: IDX_W];
  assign rword = mem[widx];

  assign do_access = ((state == IDLE) && req_valid && (LATENCY == 0)) ||
                     ((state == BUSY) && (cnt == '0));

  dmem_lane_align u_align (
    .addr_lo (acc.addr[1:0]),
    .funct3  (acc.funct3),
    .wdata   (acc.wdata),
    .rword   (rword),
    .wmask   (wmask),
    .wword   (wword),
    .ldata   (ldata)
  );

`ifdef DMEM_ERR_CHECK_EN
  always_comb begin
    acc_err = 1'b0;
    case (acc.funct3)
      F3_B:    acc_err = 1'b0;
      F3_BU:   acc_err = acc.write;
      F3_H:    acc_err = acc.addr[0];
      F3_HU:   acc_err = acc.write | acc.addr[0];
      F3_W:    acc_err = |acc.addr[1:0];
      default: acc_err = 1'b1;
    endcase
    if (acc.addr[31:2] >= 30'(DEPTH_WORDS)) acc_err = 1'b1;
  end
`else
  // Upper address bits fall away: the word index wraps modulo DEPTH_WORDS.
  logic unused_hi_addr;
  assign unused_hi_addr = ^acc.addr[31:2+IDX_W];
  assign acc_err = 1'b0;
`endif

  assign rsp_data_nxt = (!acc.write && !acc_err) ? ldata : 32'h0;

  always_ff @(posedge clk) begin
    if (do_access && acc.write && !acc_err)
      for (int i = 0; i < 4; i++)
        if (wmask[i]) mem[widx][8*i +: 8] <= wword[8*i +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_q     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          cap_q     <= acc;
          req_ready <= 1'b0;
          if (LATENCY == 0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= rsp_data_nxt;
            rsp_err   <= acc_err;
          end else begin
            state <= BUSY;
            cnt   <= CNT_INIT;
          end
        end
        BUSY: if (cnt == '0) begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= rsp_data_nxt;
          rsp_err   <= acc_err;
        end else begin
          cnt <= cnt - 1'b1;
        end
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
